// File: rtl/bitonic_16_fe_loader.sv
// Streaming front-end loader: insertion-sorts a batch of up to 16 elements into a
// bitonic vector (A ascending, B descending). BITONIC_FE_PINGPONG_EN enables two bank pairs.
module bitonic_16_fe_loader #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned DATALENGTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DATAWIDTH-1:0] x_i,
  input  logic                 last_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DATAWIDTH-1:0] y_o [DATALENGTH-1:0],
  output logic [4:0]           cnt_o
);

  localparam int unsigned HALF = 8;
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_OUT  = 1'b1;

`ifdef BITONIC_FE_PINGPONG_EN
  localparam int unsigned NP = 2;
`else
  localparam int unsigned NP = 1;
`endif

  if (DATALENGTH != 16) begin : g_len_chk
    $error("bitonic_16_fe_loader: DATALENGTH must be 16");
  end

  typedef logic [HALF-1:0][DATAWIDTH-1:0] bank_t;

  logic [0:0] r_state [NP];
  bank_t      r_a     [NP];
  bank_t      r_b     [NP];
  logic [4:0] r_cnt   [NP];
  logic [4:0] r_k;
  logic       r_wsel;
  logic       r_rsel;

  logic            w_out_hs;
  logic            w_in_acc;
  logic            w_freed;
  logic            w_to_a;
  logic            w_done;
  bank_t           w_a_base;
  bank_t           w_b_base;
  bank_t           w_a_new;
  bank_t           w_b_new;
  logic [HALF-1:0] w_ca;
  logic [HALF-1:0] w_cb;

  assign valid_o  = (r_state[r_rsel] == ST_OUT);
  // With two pairs, a pair consumed this cycle can take the incoming element at once.
  assign ready_o  = (r_state[r_wsel] == ST_FILL) || ((NP == 2) && ready_i);
  assign w_out_hs = valid_o & ready_i;
  assign w_in_acc = valid_i & ready_o;
  assign w_freed  = w_out_hs & (r_rsel == r_wsel);
  assign w_to_a   = (r_k < 5'd8);
  assign w_done   = (r_k == 5'd15) | last_i;
  assign w_a_base = w_freed ? '0 : r_a[r_wsel];
  assign w_b_base = w_freed ? '0 : r_b[r_wsel];
  assign cnt_o    = r_cnt[r_rsel];

  // Entries <= x move one slot toward the bank's low end; x lands just above them.
  always_comb begin
    w_ca    = '0;
    w_cb    = '0;
    w_a_new = w_a_base;
    w_b_new = w_b_base;
    for (int unsigned i = 0; i < HALF; i++) begin
      w_ca[i] = (w_a_base[i] <= x_i);
      w_cb[i] = (w_b_base[i] <= x_i);
    end
    for (int unsigned i = 0; i < HALF - 1; i++) begin
      w_a_new[i] = w_ca[i+1] ? w_a_base[i+1] : (w_ca[i] ? x_i : w_a_base[i]);
    end
    w_a_new[HALF-1] = w_ca[HALF-1] ? x_i : w_a_base[HALF-1];
    w_b_new[0]      = w_cb[0] ? x_i : w_b_base[0];
    for (int unsigned i = 1; i < HALF; i++) begin
      w_b_new[i] = w_cb[i-1] ? w_b_base[i-1] : (w_cb[i] ? x_i : w_b_base[i]);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < HALF; i++) begin
      y_o[i]      = r_a[r_rsel][i];
      y_o[HALF+i] = r_b[r_rsel][i];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned p = 0; p < NP; p++) begin
        r_state[p] <= ST_FILL;
        r_a[p]     <= '0;
        r_b[p]     <= '0;
        r_cnt[p]   <= '0;
      end
      r_k    <= '0;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
    end else begin
      if (w_out_hs) begin
        r_state[r_rsel] <= ST_FILL;
        r_a[r_rsel]     <= '0;
        r_b[r_rsel]     <= '0;
        r_cnt[r_rsel]   <= '0;
        r_rsel          <= (NP == 2) ? ~r_rsel : 1'b0;
      end
      // Later assignments override the clear above when the freed pair refills.
      if (w_in_acc) begin
        if (w_to_a) begin
          r_a[r_wsel] <= w_a_new;
        end else begin
          r_b[r_wsel] <= w_b_new;
        end
        if (w_done) begin
          r_state[r_wsel] <= ST_OUT;
          r_cnt[r_wsel]   <= r_k + 5'd1;
          r_k             <= '0;
          r_wsel          <= (NP == 2) ? ~r_wsel : 1'b0;
        end else begin
          r_k <= r_k + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitonic_16_fe_loader.sv
// Bench for bitonic_16_fe_loader: sort-based reference model plus directed batches.
module tb_bitonic_16_fe_loader;

`ifdef BITONIC_FE_PINGPONG_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] x_i;
  logic       last_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] y_o [15:0];
  logic [4:0] cnt_o;

  always #5 clk_i = ~clk_i;

  bitonic_16_fe_loader #(.DATAWIDTH(8), .DATALENGTH(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .x_i(x_i), .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i),
    .y_o(y_o), .cnt_o(cnt_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_pops = 0;
  bit chk_en = 0;
  bit tog_en = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0][7:0] y;
    logic [4:0]       cnt;
  } vec_t;

  vec_t       done_q[$];
  logic [7:0] fill_q[$];

  // Reference: first 8 elements sorted ascending, rest sorted descending, zero padded.
  function automatic vec_t build(input logic [7:0] e[$]);
    logic [7:0] a[8];
    logic [7:0] b[8];
    logic [7:0] t;
    vec_t v;
    for (int i = 0; i < 8; i++) begin a[i] = 8'd0; b[i] = 8'd0; end
    for (int i = 0; i < e.size(); i++) begin
      if (i < 8) a[i] = e[i]; else b[i-8] = e[i];
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 7 - i; j++) begin
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        if (b[j] < b[j+1]) begin t = b[j]; b[j] = b[j+1]; b[j+1] = t; end
      end
    end
    for (int i = 0; i < 8; i++) begin v.y[i] = a[i]; v.y[8+i] = b[i]; end
    v.cnt = 5'(e.size());
    return v;
  endfunction

  function automatic logic exp_ready();
    return (done_q.size() < NP) || ((NP == 2) && ready_i);
  endfunction

  always @(posedge clk_i) cyc++;

  always @(posedge clk_i or negedge rstn_i) begin : model
    bit hs, acc;
    if (!rstn_i) begin
      done_q.delete();
      fill_q.delete();
    end else begin
      hs  = (done_q.size() > 0) && ready_i;
      acc = valid_i && exp_ready();
      if (hs) begin
        void'(done_q.pop_front());
        n_pops++;
      end
      if (acc) begin
        fill_q.push_back(x_i);
        if (fill_q.size() == 16 || last_i) begin
          done_q.push_back(build(fill_q));
          fill_q.delete();
        end
      end
    end
  end

  always @(negedge clk_i) begin : compare
    logic [15:0][7:0] ypk;
    #2;
    if (chk_en) begin
      for (int i = 0; i < 16; i++) ypk[i] = y_o[i];
      check("ready_o", ready_o, exp_ready());
      check("valid_o", valid_o, done_q.size() > 0);
      if (done_q.size() > 0) begin
        check("y_o", ypk, done_q[0].y);
        check("cnt_o", cnt_o, done_q[0].cnt);
      end
    end
  end

  always @(negedge clk_i) if (tog_en) ready_i = ~ready_i;

  task automatic send(input logic [7:0] x, input logic l);
    logic acc;
    int unsigned guard;
    guard = 0;
    @(negedge clk_i);
    valid_i = 1'b1; x_i = x; last_i = l;
    forever begin
      #1 acc = ready_o;
      @(posedge clk_i);
      if (acc) break;
      guard++;
      if (guard > 64) begin
        check("send_timeout", ready_o, 1'b1);
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic idle(input int n, input logic l);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      valid_i = 1'b0; last_i = l;
    end
    last_i = 1'b0;
  endtask

  task automatic pin(input string name, input logic [7:0] e[16], input logic [4:0] c);
    logic [15:0][7:0] ex, ac;
    for (int i = 0; i < 16; i++) begin ex[i] = e[i]; ac[i] = y_o[i]; end
    check({name, "_valid"}, valid_o, 1'b1);
    check({name, "_y"}, ac, ex);
    check({name, "_cnt"}, cnt_o, c);
  endtask

  task automatic check_zero_state(input string name);
    logic [15:0][7:0] ac;
    for (int i = 0; i < 16; i++) ac[i] = y_o[i];
    check({name, "_ready"}, ready_o, 1'b1);
    check({name, "_valid"}, valid_o, 1'b0);
    check({name, "_cnt"}, cnt_o, 5'd0);
    check({name, "_y"}, ac, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e16[16];
    int c0, p0;
    rstn_i = 1'b0; valid_i = 1'b0; x_i = 8'd0; last_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_en = 1;
    #1 check_zero_state("reset");
    @(negedge clk_i);
    rstn_i = 1'b1;

    // 1: ascending 0..15
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    @(negedge clk_i); valid_i = 1'b0;
    e16 = '{0,1,2,3,4,5,6,7,15,14,13,12,11,10,9,8};
    #1 pin("t1", e16, 5'd16);
    @(negedge clk_i);
    #1 check("t1_consumed", valid_o, 1'b0);

    // last_i without valid_i must have no effect
    idle(3, 1'b1);

    // 2: short batch 3,9,1
    send(8'd3, 1'b0); send(8'd9, 1'b0); send(8'd1, 1'b1);
    @(negedge clk_i); valid_i = 1'b0; last_i = 1'b0;
    e16 = '{0,0,0,0,0,1,3,9,0,0,0,0,0,0,0,0};
    #1 pin("t2", e16, 5'd3);
    idle(2, 1'b0);

    // 9-element batch: first element of bank B
    send(8'd4, 1'b0); send(8'd8, 1'b0); send(8'd6, 1'b0); send(8'd2, 1'b0);
    send(8'd7, 1'b0); send(8'd1, 1'b0); send(8'd3, 1'b0); send(8'd5, 1'b0);
    send(8'd9, 1'b1);
    @(negedge clk_i); valid_i = 1'b0; last_i = 1'b0;
    e16 = '{1,2,3,4,5,6,7,8,9,0,0,0,0,0,0,0};
    #1 pin("t9", e16, 5'd9);
    idle(2, 1'b0);

    // 3: backpressure for 10 cycles
    ready_i = 1'b0;
    for (int i = 0; i < 16; i++) send(8'((i * 13 + 7) & 255), 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i); valid_i = 1'b0;
      #1 check("t3_hold_valid", valid_o, 1'b1);
    end
    @(negedge clk_i); ready_i = 1'b1;
    @(negedge clk_i);
    #1 check("t3_released_valid", valid_o, 1'b0);
    check("t3_released_ready", ready_o, 1'b1);

    // 4: reset after 7 elements, then 16 x FF
    for (int i = 0; i < 7; i++) send(8'(i + 40), 1'b0);
    @(negedge clk_i); valid_i = 1'b0; rstn_i = 1'b0;
    #1 check_zero_state("t4_reset");
    @(negedge clk_i); rstn_i = 1'b1;
    for (int i = 0; i < 16; i++) send(8'hFF, 1'b0);
    @(negedge clk_i); valid_i = 1'b0;
    for (int i = 0; i < 16; i++) e16[i] = 8'hFF;
    #1 pin("t4", e16, 5'd16);
    idle(2, 1'b0);

    // 5: duplicates, last_i on the 16th element
    e16 = '{5,5,2,2,7,7,0,0,9,9,3,3,1,1,8,8};
    for (int i = 0; i < 16; i++) send(e16[i], (i == 15));
    @(negedge clk_i); valid_i = 1'b0; last_i = 1'b0;
    e16 = '{0,0,2,2,5,5,7,7,9,9,8,8,3,3,1,1};
    #1 pin("t5", e16, 5'd16);
    idle(2, 1'b0);

`ifdef BITONIC_FE_PINGPONG_EN
    // 6: 48 back-to-back elements with downstream toggling
    p0 = n_pops;
    tog_en = 1;
    c0 = cyc;
    for (int i = 0; i < 48; i++) send(8'((i * 37) & 255), 1'b0);
    check("t6_cycles", 32'(cyc - c0), 32'd48);
    @(negedge clk_i); valid_i = 1'b0;
    tog_en = 0;
    ready_i = 1'b1;
    idle(8, 1'b0);
    check("t6_vectors", 32'(n_pops - p0), 32'd3);
`else
    p0 = 0; c0 = 0;
`endif

    idle(3, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
